// File: rtl/i2c_controller_pkg.sv
// Shared types and the sensor power-up register table for the SCCB configuration master.
package i2c_controller_pkg;

    typedef enum logic [3:0] {
        RESET_HOLD,
        STARTUP_WAIT,
        START,
        SEND_BIT,
        ACK,
        STOP,
        GAP,
        DONE,
        ERROR
    } state_t;

    localparam int NUM_REGS = 4;

    // Entry i is {register, value}; entry 0 is the rightmost element.
    localparam logic [NUM_REGS-1:0][15:0] CFG_TABLE = {
        {8'h11, 8'h01},
        {8'h40, 8'hD0},
        {8'h12, 8'h04},
        {8'h12, 8'h80}
    };

    // Byte sel of a transaction: 0 = device address, 1 = register, 2 = value.
    function automatic logic [7:0] tx_byte(input logic [7:0] dev,
                                           input logic [1:0] idx,
                                           input logic [1:0] sel);
        case (sel)
            2'd0:    return dev;
            2'd1:    return CFG_TABLE[idx][15:8];
            default: return CFG_TABLE[idx][7:0];
        endcase
    endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator: tick_o pulses on the last cycle of each CLK_DIV-cycle quarter,
// first_o marks the first cycle of a quarter. Held at reload while disabled.
module i2c_clk_div #(
    parameter int CLK_DIV = 250
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tick_o,
    output logic first_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || cnt_q == '0) begin
            cnt_d = LOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o  = en_i && (cnt_q == '0);
    assign first_o = en_i && (cnt_q == LOAD);

endmodule

// File: rtl/i2c_controller.sv
// Camera power-up sequencer: releases the sensor reset, waits, then writes CFG_TABLE over SCCB.
//
// state        | meaning
// RESET_HOLD   | camera held in reset for RESET_DELAY cycles
// STARTUP_WAIT | camera released, waiting STARTUP_DELAY cycles
// START        | q0 bus idle, q1 SDA low with SCL high
// SEND_BIT     | one data bit, MSB first, 4 quarters
// ACK          | 9th bit, SDA released and sampled in q3
// STOP         | q0 SDA low/SCL low, q1 SCL high, q2 SDA released
// GAP          | 4 idle quarters between transactions
// DONE         | table written, bus idle
// ERROR        | NACK seen, bus idle, error_o held
module i2c_controller
    import i2c_controller_pkg::*;
#(
    parameter int          RESET_DELAY   = 1000,
    parameter int          STARTUP_DELAY = 1000,
    parameter int          CLK_DIV       = 250,
    parameter logic [7:0]  DEV_ADDR      = 8'h42
) (
    input  logic clk_i,
    input  logic reset_i,
    inout  wire  sda_io,
    output logic scl_o,
    output logic reset_cmos_o,
    output logic error_o
);
    localparam int DMAX = (RESET_DELAY > STARTUP_DELAY) ? RESET_DELAY : STARTUP_DELAY;
    localparam int DW   = $clog2(DMAX + 1);
    localparam logic [DW-1:0] RST_TC = DW'(RESET_DELAY - 1);
    localparam logic [DW-1:0] SU_TC  = DW'(STARTUP_DELAY - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [2:0]    idx_q, idx_d;
    logic          error_q, error_d;
    logic          cmos_q, cmos_d;
    logic          tick, first, div_en;
    logic          scl_c, sda_oe;
    logic [7:0]    cur_byte;

    assign div_en   = (state_q != RESET_HOLD) && (state_q != STARTUP_WAIT) &&
                      (state_q != DONE) && (state_q != ERROR);
    assign cur_byte = tx_byte(DEV_ADDR, idx_q[1:0], byte_q);

    i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (div_en),
        .tick_o (tick),
        .first_o(first)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= RESET_HOLD;
            dly_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            error_q <= 1'b0;
            cmos_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            error_q <= error_d;
            cmos_q  <= cmos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        error_d = error_q;
        cmos_d  = cmos_q;
        case (state_q)
            RESET_HOLD: begin
                if (dly_q == RST_TC) begin
                    dly_d   = '0;
                    cmos_d  = 1'b1;
                    state_d = STARTUP_WAIT;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            STARTUP_WAIT: begin
                if (dly_q == SU_TC) begin
                    dly_d   = '0;
                    state_d = START;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (qtr_q == 2'd1) begin
                        qtr_d   = '0;
                        bit_d   = 3'd7;
                        byte_d  = '0;
                        state_d = SEND_BIT;
                    end else begin
                        qtr_d = qtr_q + 1'b1;
                    end
                end
            end
            SEND_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == '0) state_d = ACK;
                        else             bit_d   = bit_q - 1'b1;
                    end
                end
            end
            ACK: begin
                // A floating or high line both count as NACK.
                if (first && qtr_q == 2'd3) begin
                    if (sda_io == 1'b0) error_d = error_q;
                    else                error_d = 1'b1;
                end
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        if (error_d || byte_q == 2'd2) begin
                            state_d = STOP;
                        end else begin
                            bit_d   = 3'd7;
                            byte_d  = byte_q + 1'b1;
                            state_d = SEND_BIT;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d   = '0;
                        state_d = error_q ? ERROR : GAP;
                    end else begin
                        qtr_d = qtr_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = (idx_q == 3'(NUM_REGS - 1)) ? DONE : START;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        scl_c  = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            START:    sda_oe = (qtr_q == 2'd1);
            SEND_BIT: begin
                scl_c  = qtr_q[1];
                sda_oe = ~cur_byte[bit_q];
            end
            ACK:      scl_c = qtr_q[1];
            STOP: begin
                scl_c  = (qtr_q != 2'd0);
                sda_oe = (qtr_q != 2'd2);
            end
            default: ;
        endcase
    end

    assign sda_io       = sda_oe ? 1'b0 : 1'bz;
    assign scl_o        = scl_c;
    assign reset_cmos_o = cmos_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: bus monitor + ACKing slave model, expected bytes from a plain table.
module tb_i2c_controller;

    localparam int D          = 4;
    localparam int RUN_CYCLES = 2500;

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    logic scl_o, reset_cmos_o, error_o;
    wire  sda;
    logic slave_drive;

    always #5 clk = ~clk;

    assign sda = slave_drive ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_controller #(
        .RESET_DELAY  (1),
        .STARTUP_DELAY(20),
        .CLK_DIV      (D),
        .DEV_ADDR     (8'h42)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .sda_io      (sda),
        .scl_o       (scl_o),
        .reset_cmos_o(reset_cmos_o),
        .error_o     (error_o)
    );

    // Reference: the complete byte stream of the configuration sequence.
    logic [7:0] exp_stream [12] = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h12, 8'h04,
                                    8'h42, 8'h40, 8'hD0, 8'h42, 8'h11, 8'h01};

    int tests = 0;
    int fails = 0;
    int nack_at = 12;   // global byte number the slave refuses; >=12 means ACK all

    int         cyc = 0;
    logic [7:0] mon_bytes [$];
    logic       mon_acks  [$];
    int starts, stops, frame_err, tim_err, rises, byte_no, bit_idx;
    int t_rise, t_fall, low_w, err_dt, rises_at_err;
    logic in_txn, pend, bit_val, prev_scl, prev_sda, prev_err, scl_now, sda_now;
    logic [7:0] shreg;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_i) begin
            mon_bytes.delete();
            mon_acks.delete();
            starts = 0; stops = 0; frame_err = 0; tim_err = 0; rises = 0;
            byte_no = 0; bit_idx = 0; t_rise = 0; t_fall = 0; low_w = 0;
            err_dt = -1; rises_at_err = -1;
            in_txn = 0; pend = 0; bit_val = 0; shreg = '0;
            prev_scl = 1; prev_sda = 1; prev_err = 0;
            slave_drive = 0;
        end else begin
            scl_now = scl_o;
            sda_now = (sda !== 1'b0);
            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                if (in_txn) frame_err++;
                starts++;
                in_txn = 1; bit_idx = 0; pend = 0; shreg = '0;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                if (!in_txn || bit_idx != 0) frame_err++;
                stops++;
                in_txn = 0; pend = 0;
            end else if (!prev_scl && scl_now) begin
                rises++;
                if (in_txn) begin
                    low_w = cyc - t_fall; t_rise = cyc; bit_val = sda_now; pend = 1;
                end
            end else if (prev_scl && !scl_now) begin
                if (in_txn && pend) begin
                    if (low_w != 2 * D) tim_err++;
                    if (cyc - t_rise != 2 * D) tim_err++;
                    pend = 0;
                    if (bit_idx < 8) begin
                        shreg = {shreg[6:0], bit_val};
                        bit_idx++;
                        if (bit_idx == 8) slave_drive = (byte_no != nack_at);
                    end else begin
                        mon_bytes.push_back(shreg);
                        mon_acks.push_back(bit_val);
                        byte_no++; bit_idx = 0; slave_drive = 0;
                    end
                end
                t_fall = cyc;
            end
            if (error_o && !prev_err) begin
                err_dt = cyc - t_rise;
                rises_at_err = rises;
            end
            prev_err = error_o;
            prev_scl = scl_now;
            prev_sda = sda_now;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic verify(input int k);
        int nsent;
        int ntx;
        nsent = (k < 12) ? k + 1 : 12;
        ntx   = (k < 12) ? k / 3 + 1 : 4;
        check("byte_count", mon_bytes.size(), nsent);
        for (int i = 0; i < nsent && i < mon_bytes.size(); i++) begin
            check($sformatf("byte%0d", i), mon_bytes[i], exp_stream[i]);
            check($sformatf("ack%0d", i), mon_acks[i], (i == k) ? 1 : 0);
        end
        check("starts", starts, ntx);
        check("stops", stops, ntx);
        check("framing", frame_err, 0);
        check("scl_timing", tim_err, 0);
        check("error_o", error_o, (k < 12) ? 1 : 0);
        if (k < 12) begin
            check("err_delay", err_dt, D + 1);
            check("post_err_rises", rises - rises_at_err, 1);
        end
        check("end_scl", scl_o, 1);
        check("end_sda", (sda !== 1'b0), 1);
        check("end_cmos", reset_cmos_o, 1);
    endtask

    task automatic start_run(input int k);
        @(negedge clk);
        reset_i = 0;
        nack_at = k;
        repeat (2) @(negedge clk);
        reset_i = 1;
    endtask

    initial begin
        int k;
        // Power-up reset behaviour with RESET_DELAY=1.
        reset_i = 0;
        nack_at = 12;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmos", reset_cmos_o, 0);
        check("rst_scl", scl_o, 1);
        check("rst_sda", (sda !== 1'b0), 1);
        check("rst_err", error_o, 0);
        @(negedge clk);
        reset_i = 1;
        #1;
        check("cmos_before_edge", reset_cmos_o, 0);
        @(posedge clk);
        #1;
        check("cmos_after_edge", reset_cmos_o, 1);
        check("wait_scl", scl_o, 1);
        check("wait_sda", (sda !== 1'b0), 1);
        repeat (RUN_CYCLES) @(posedge clk);
        #1;
        verify(12);

        // No slave at all, then NACK on the value byte of the second entry.
        start_run(0);
        repeat (RUN_CYCLES) @(posedge clk);
        #1;
        verify(0);
        start_run(5);
        repeat (RUN_CYCLES) @(posedge clk);
        #1;
        verify(5);

        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(0, 12);
            start_run(k);
            repeat (RUN_CYCLES) @(posedge clk);
            #1;
            verify(k);
        end

        // Asynchronous reset in the middle of the sequence, after an earlier error.
        start_run(0);
        repeat (400) @(posedge clk);
        #1;
        check("pre_reset_err", error_o, 1);
        @(negedge clk);
        reset_i = 0;
        nack_at = 12;
        repeat (2) @(negedge clk);
        reset_i = 1;
        repeat ($urandom_range(100, 1800)) @(posedge clk);
        #3;
        reset_i = 0;
        #1;
        check("mid_rst_cmos", reset_cmos_o, 0);
        check("mid_rst_scl", scl_o, 1);
        check("mid_rst_err", error_o, 0);
        @(negedge clk);
        #2;
        check("mid_rst_sda", (sda !== 1'b0), 1);
        @(negedge clk);
        reset_i = 1;
        repeat (RUN_CYCLES) @(posedge clk);
        #1;
        verify(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
